// File: rtl/hex_disp_pkg.sv
// Shared definitions for the hex display scan path: digit width, the
// all-digits-dark select pattern, default timing values and the blink phase type.
package hex_disp_pkg;

   localparam int DIGIT_W             = 4;
   localparam int MAX_DIGITS          = 16;
   localparam int DEFAULT_TICK_DIV    = 50000;
   localparam int DEFAULT_BLINK_TICKS = 250;

   localparam logic [MAX_DIGITS-1:0] SEL_ALL_OFF = '1;

   typedef enum logic {
      PHASE_ON  = 1'b0,
      PHASE_OFF = 1'b1
   } blink_phase_e;

   // Counter width for a modulus, never less than one bit.
   function automatic int cnt_width(input int modulus);
      return (modulus > 1) ? $clog2(modulus) : 1;
   endfunction

endpackage

// File: rtl/hex_scan_driver_if.sv
// Valid/ready load port of the hex scan driver: a source pushes a full
// multi-digit hex value, the driver accepts it when its shadow buffer is free.
interface hex_scan_driver_if
   import hex_disp_pkg::*;
#(
   parameter int NUM_DIGITS = 4
) ();

   logic                            load_valid;
   logic [DIGIT_W*NUM_DIGITS-1:0]   load_data;
   logic                            load_ready;

   modport master (
      output load_valid,
      output load_data,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_data,
      output load_ready
   );

endinterface

// File: rtl/scan_tick_gen.sv
// Scan prescaler: counts 0..TICK_DIV-1 and wraps; tick is high for the
// single cycle in which the count sits at TICK_DIV-1.
module scan_tick_gen
   import hex_disp_pkg::*;
#(
   parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int            CW   = cnt_width(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q + CW'(1);
      if (count_q == LAST) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick = (count_q == LAST);

endmodule

// File: rtl/hex_scan_driver.sv
// Multiplexed hex display feeder: double-buffers a loaded value, commits it only
// at frame boundaries, and scans one nibble per step with blanking and blink.
module hex_scan_driver
   import hex_disp_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int TICK_DIV    = DEFAULT_TICK_DIV,
   parameter int BLINK_TICKS = DEFAULT_BLINK_TICKS
) (
   input  logic                  clk,
   input  logic                  reset_n,
   hex_scan_driver_if.slave      load_if,
   input  logic                  blank_lz,
   input  logic                  blink_en,
   output logic [DIGIT_W-1:0]    digit_nibble,
   output logic [NUM_DIGITS-1:0] digit_sel_n
);

   localparam int DW = DIGIT_W * NUM_DIGITS;
   localparam int IW = cnt_width(NUM_DIGITS);
   localparam int BW = cnt_width(BLINK_TICKS);

   localparam logic [IW-1:0]         LAST_IDX   = IW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0]         LAST_BLINK = BW'(BLINK_TICKS - 1);
   localparam logic [NUM_DIGITS-1:0] SEL_OFF    = SEL_ALL_OFF[NUM_DIGITS-1:0];

   if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
      $error("hex_scan_driver: NUM_DIGITS out of range");
   end
   if (TICK_DIV < 2) begin : g_bad_tick
      $error("hex_scan_driver: TICK_DIV must be at least 2");
   end
   if (BLINK_TICKS < 1) begin : g_bad_blink
      $error("hex_scan_driver: BLINK_TICKS must be at least 1");
   end

   logic tick;
   logic frame_end;
   logic accept;
   logic commit;
   logic upper_nonzero;
   logic blank;
   logic blink_off;

   logic [IW-1:0]         scan_idx_q,  scan_idx_d;
   logic                  pending_q,   pending_d;
   logic [DW-1:0]         shadow_q,    shadow_d;
   logic [DW-1:0]         disp_q,      disp_d;
   logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
   blink_phase_e          phase_q,     phase_d;
   logic [DIGIT_W-1:0]    nibble_q,    nibble_d;
   logic [NUM_DIGITS-1:0] sel_q,       sel_d;

   scan_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick)
   );

   assign frame_end = tick && (scan_idx_q == LAST_IDX);
   assign accept    = load_if.load_valid && !pending_q;
   assign commit    = frame_end && pending_q;

   // A new value sits in the shadow until the last digit of a frame has been
   // shown, so a frame is always drawn entirely from one loaded value.
   always_comb begin
      pending_d = pending_q;
      shadow_d  = shadow_q;
      disp_d    = disp_q;
      if (accept) begin
         shadow_d  = load_if.load_data;
         pending_d = 1'b1;
      end else if (commit) begin
         disp_d    = shadow_q;
         pending_d = 1'b0;
      end
   end

   always_comb begin
      scan_idx_d  = scan_idx_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (tick) begin
         scan_idx_d = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + IW'(1);
         if (blink_cnt_q == LAST_BLINK) begin
            blink_cnt_d = '0;
            phase_d     = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
         end
      end
   end

   // Leading-zero test: the current digit is blank when it and every more
   // significant digit are zero; digit 0 always stays lit.
   always_comb begin
      upper_nonzero = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (k >= int'(scan_idx_q) && disp_q[DIGIT_W*k +: DIGIT_W] != '0) begin
            upper_nonzero = 1'b1;
         end
      end
      blank     = blank_lz && (scan_idx_q != '0) && !upper_nonzero;
      blink_off = blink_en && (phase_q == PHASE_OFF);
   end

   always_comb begin
      nibble_d = disp_q[DIGIT_W*scan_idx_q +: DIGIT_W];
      sel_d    = ~(NUM_DIGITS'(1) << scan_idx_q);
      if (blank || blink_off) begin
         sel_d = SEL_OFF;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scan_idx_q  <= '0;
         pending_q   <= 1'b0;
         shadow_q    <= '0;
         disp_q      <= '0;
         blink_cnt_q <= '0;
         phase_q     <= PHASE_ON;
         nibble_q    <= '0;
         sel_q       <= SEL_OFF;
      end else begin
         scan_idx_q  <= scan_idx_d;
         pending_q   <= pending_d;
         shadow_q    <= shadow_d;
         disp_q      <= disp_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         nibble_q    <= nibble_d;
         sel_q       <= sel_d;
      end
   end

   assign load_if.load_ready = !pending_q;
   assign digit_nibble       = nibble_q;
   assign digit_sel_n        = sel_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Randomized bench for hex_scan_driver against a cycle-count based reference
// model of scan position, blink phase, double buffering and blanking.
module tb_hex_scan_driver;
   import hex_disp_pkg::*;

   localparam int ND = 4;
   localparam int TD = 4;
   localparam int BT = 2;

   logic          clk      = 1'b0;
   logic          reset_n  = 1'b0;
   logic          blank_lz = 1'b0;
   logic          blink_en = 1'b0;
   logic [3:0]    digit_nibble;
   logic [ND-1:0] digit_sel_n;

   hex_scan_driver_if #(.NUM_DIGITS(ND)) load_if ();

   hex_scan_driver #(
      .NUM_DIGITS  (ND),
      .TICK_DIV    (TD),
      .BLINK_TICKS (BT)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .load_if      (load_if.slave),
      .blank_lz     (blank_lz),
      .blink_en     (blink_en),
      .digit_nibble (digit_nibble),
      .digit_sel_n  (digit_sel_n)
   );

   always #5 clk = ~clk;

   int          checkCount = 0;
   int          errorCount = 0;
   int          edgeNum;
   bit          modelPending;
   logic [15:0] modelShadow;
   logic [15:0] modelDisp;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h (edge %0d)",
                  tag, observed, expected, edgeNum);
      end
   endtask

   function automatic int sigDigits(input logic [15:0] v);
      int n = 1;
      int x = int'(v);
      while (x >= 16) begin
         x = x / 16;
         n++;
      end
      return n;
   endfunction

   task automatic resetModel();
      edgeNum      = 0;
      modelPending = 1'b0;
      modelShadow  = '0;
      modelDisp    = '0;
   endtask

   // Called at a negedge: a source holding valid while stalled keeps its data.
   task automatic applyStimulus(input int validPct);
      logic [15:0] d;
      if (load_if.load_valid && !load_if.load_ready) return;
      d = '0;
      for (int i = 0; i < ND; i++) begin
         if ($urandom_range(1, 0) == 1) d[4*i +: 4] = 4'($urandom_range(15, 0));
      end
      load_if.load_data  = d;
      load_if.load_valid = ($urandom_range(99, 0) < validPct);
   endtask

   // Called at a negedge; returns at a negedge after count modelled edges.
   task automatic runCycles(input int count, input int validPct);
      int            idx;
      bit            tickNow;
      bit            phaseOff;
      bit            blanked;
      bit            acceptNow;
      logic [ND-1:0] expSel;
      logic [3:0]    expNib;
      repeat (count) begin
         applyStimulus(validPct);
         idx      = (edgeNum / TD) % ND;
         tickNow  = (edgeNum % TD) == TD - 1;
         phaseOff = ((edgeNum / TD) / BT) % 2 == 1;
         blanked  = blank_lz && (idx >= sigDigits(modelDisp));
         expNib   = 4'((modelDisp >> (4 * idx)) & 16'hF);
         expSel   = (blanked || (blink_en && phaseOff)) ? '1 : ~(ND'(1) << idx);
         acceptNow = load_if.load_valid && !modelPending;
         @(posedge clk);
         #1;
         checkOutput("digit_sel_n", 32'(digit_sel_n), 32'(expSel));
         checkOutput("digit_nibble", 32'(digit_nibble), 32'(expNib));
         if (acceptNow) begin
            modelShadow  = load_if.load_data;
            modelPending = 1'b1;
         end else if (tickNow && idx == ND - 1 && modelPending) begin
            modelDisp    = modelShadow;
            modelPending = 1'b0;
         end
         edgeNum++;
         checkOutput("load_ready", 32'(load_if.load_ready), 32'(!modelPending));
         @(negedge clk);
      end
   endtask

   initial begin
      load_if.load_valid = 1'b0;
      load_if.load_data  = '0;
      resetModel();
      #12;
      checkOutput("reset digit_sel_n", 32'(digit_sel_n), 32'hF);
      checkOutput("reset digit_nibble", 32'(digit_nibble), 32'h0);
      checkOutput("reset load_ready", 32'(load_if.load_ready), 32'h1);

      @(negedge clk);
      reset_n = 1'b1;
      resetModel();
      runCycles(20, 0);
      runCycles(200, 30);
      blank_lz = 1'b1;
      runCycles(200, 30);
      blink_en = 1'b1;
      runCycles(200, 20);
      blank_lz = 1'b0;
      runCycles(100, 20);
      blink_en = 1'b0;
      runCycles(50, 20);
      for (int r = 0; r < 10; r++) begin
         blank_lz = 1'($urandom_range(1, 0));
         blink_en = 1'($urandom_range(1, 0));
         runCycles(37, 25);
      end

      // Async reset while a value is waiting in the shadow buffer.
      for (int w = 0; w < 40 && modelPending; w++) runCycles(1, 0);
      runCycles(1, 100);
      checkOutput("pending before reset", 32'(load_if.load_ready), 32'(!modelPending));
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async reset digit_sel_n", 32'(digit_sel_n), 32'hF);
      checkOutput("async reset digit_nibble", 32'(digit_nibble), 32'h0);
      checkOutput("async reset load_ready", 32'(load_if.load_ready), 32'h1);
      @(negedge clk);
      load_if.load_valid = 1'b0;
      blank_lz = 1'b0;
      blink_en = 1'b0;
      reset_n  = 1'b1;
      resetModel();
      runCycles(40, 0);

      $display("[TB] Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
